// File: rtl/alu_rs_pkg.sv
// Shared types and constants for the ALU reservation station.
// Op codes are passed through unchanged; only OP_NONE has meaning to the RS.
package alu_rs_pkg;

    localparam int DEF_RS_SIZE = 8;
    localparam int ROB_W       = 4;
    localparam int OP_W        = 6;

    localparam logic [OP_W-1:0] OP_NONE = 6'd0;
    localparam logic [OP_W-1:0] OP_ADD  = 6'd1;
    localparam logic [OP_W-1:0] OP_SUB  = 6'd2;
    localparam logic [OP_W-1:0] OP_XOR  = 6'd3;
    localparam logic [OP_W-1:0] OP_BEQ  = 6'd4;

    typedef struct packed {
        logic              busy;
        logic [OP_W-1:0]   op;
        logic [31:0]       vj;
        logic [31:0]       vk;
        logic [ROB_W-1:0]  qj;
        logic [ROB_W-1:0]  qk;
        logic              qj_busy;
        logic              qk_busy;
        logic [ROB_W-1:0]  robid;
    } rs_entry_t;

    typedef struct packed {
        logic        busy;
        logic [31:0] val;
    } operand_t;

    // Resolve one operand against both CDB sources; ALU wins if both match.
    function automatic operand_t snoop(
        input logic             busy,
        input logic [ROB_W-1:0] tag,
        input logic [31:0]      val,
        input logic             alu_valid,
        input logic [ROB_W-1:0] alu_robid,
        input logic [31:0]      alu_result,
        input logic             lsb_valid,
        input logic [ROB_W-1:0] lsb_robid,
        input logic [31:0]      lsb_result
    );
        operand_t res;
        res.busy = busy;
        res.val  = val;
        if (busy && alu_valid && (alu_robid == tag)) begin
            res.busy = 1'b0;
            res.val  = alu_result;
        end else if (busy && lsb_valid && (lsb_robid == tag)) begin
            res.busy = 1'b0;
            res.val  = lsb_result;
        end
        return res;
    endfunction

endpackage

// File: rtl/alu_rs_pick.sv
// Priority encoder: lowest free entry for issue and lowest ready entry for dispatch.
module alu_rs_pick #(
    parameter int RS_SIZE = 8,
    parameter int IDX_W   = $clog2(RS_SIZE)
) (
    input  logic [RS_SIZE-1:0] busy_vec,
    input  logic [RS_SIZE-1:0] ready_vec,
    output logic [IDX_W-1:0]   free_idx,
    output logic               free_valid,
    output logic [IDX_W-1:0]   ready_idx,
    output logic               ready_valid
);

    // Scan from the top down so the lowest matching index wins.
    always_comb begin
        free_idx    = '0;
        free_valid  = 1'b0;
        ready_idx   = '0;
        ready_valid = 1'b0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!busy_vec[i]) begin
                free_idx   = IDX_W'(i);
                free_valid = 1'b1;
            end
            if (ready_vec[i]) begin
                ready_idx   = IDX_W'(i);
                ready_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_rs.sv
// ALU reservation station: buffers issued instructions, wakes operands from the
// CDB and dispatches at most one ready entry per cycle through registered outputs.
module alu_rs
    import alu_rs_pkg::*;
#(
    parameter int RS_SIZE = DEF_RS_SIZE
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             rdy_in,
    input  logic             rob_clear,
    input  logic             issue_valid,
    input  logic [OP_W-1:0]  issue_op,
    input  logic [31:0]      issue_vj,
    input  logic [31:0]      issue_vk,
    input  logic             issue_qj_busy,
    input  logic             issue_qk_busy,
    input  logic [ROB_W-1:0] issue_qj,
    input  logic [ROB_W-1:0] issue_qk,
    input  logic [ROB_W-1:0] issue_robid,
    output logic             rs_full,
    input  logic             alu_valid,
    input  logic [ROB_W-1:0] alu_robid,
    input  logic [31:0]      alu_result,
    input  logic             lsb_valid,
    input  logic [ROB_W-1:0] lsb_robid,
    input  logic [31:0]      lsb_result,
    output logic [31:0]      rs1,
    output logic [31:0]      rs2,
    output logic [OP_W-1:0]  op,
    output logic [ROB_W-1:0] robid
);

    localparam int IDX_W = $clog2(RS_SIZE);

    rs_entry_t entries_q [RS_SIZE];
    rs_entry_t entries_d [RS_SIZE];

    logic [31:0]      rs1_q, rs1_d;
    logic [31:0]      rs2_q, rs2_d;
    logic [OP_W-1:0]  op_q, op_d;
    logic [ROB_W-1:0] robid_q, robid_d;

    logic [RS_SIZE-1:0] busy_vec;
    logic [RS_SIZE-1:0] ready_vec;
    logic [IDX_W-1:0]   free_idx;
    logic               free_valid;
    logic [IDX_W-1:0]   ready_idx;
    logic               ready_valid;

    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            busy_vec[i]  = entries_q[i].busy;
            ready_vec[i] = entries_q[i].busy && !entries_q[i].qj_busy && !entries_q[i].qk_busy;
        end
    end

    // Full means every entry is busy in registered state; free_valid is its complement.
    assign rs_full = !free_valid;

    alu_rs_pick #(
        .RS_SIZE (RS_SIZE),
        .IDX_W   (IDX_W)
    ) u_pick (
        .busy_vec    (busy_vec),
        .ready_vec   (ready_vec),
        .free_idx    (free_idx),
        .free_valid  (free_valid),
        .ready_idx   (ready_idx),
        .ready_valid (ready_valid)
    );

    always_comb begin
        operand_t opj;
        operand_t opk;
        entries_d = entries_q;
        rs1_d     = rs1_q;
        rs2_d     = rs2_q;
        robid_d   = robid_q;
        op_d      = OP_NONE;
        opj       = '0;
        opk       = '0;

        if (rob_clear) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                entries_d[i] = '0;
            end
            rs1_d   = '0;
            rs2_d   = '0;
            robid_d = '0;
        end else if (rdy_in) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (entries_q[i].busy) begin
                    opj = snoop(entries_q[i].qj_busy, entries_q[i].qj, entries_q[i].vj,
                                alu_valid, alu_robid, alu_result,
                                lsb_valid, lsb_robid, lsb_result);
                    opk = snoop(entries_q[i].qk_busy, entries_q[i].qk, entries_q[i].vk,
                                alu_valid, alu_robid, alu_result,
                                lsb_valid, lsb_robid, lsb_result);
                    entries_d[i].qj_busy = opj.busy;
                    entries_d[i].vj      = opj.val;
                    entries_d[i].qk_busy = opk.busy;
                    entries_d[i].vk      = opk.val;
                end
            end

            // Dispatch uses pre-wakeup state, so a CDB value never reaches the ALU on the same edge.
            if (ready_valid) begin
                rs1_d   = entries_q[ready_idx].vj;
                rs2_d   = entries_q[ready_idx].vk;
                op_d    = entries_q[ready_idx].op;
                robid_d = entries_q[ready_idx].robid;
                entries_d[ready_idx].busy = 1'b0;
            end

            if (issue_valid && free_valid) begin
                opj = snoop(issue_qj_busy, issue_qj, issue_vj,
                            alu_valid, alu_robid, alu_result,
                            lsb_valid, lsb_robid, lsb_result);
                opk = snoop(issue_qk_busy, issue_qk, issue_vk,
                            alu_valid, alu_robid, alu_result,
                            lsb_valid, lsb_robid, lsb_result);
                entries_d[free_idx].busy    = 1'b1;
                entries_d[free_idx].op      = issue_op;
                entries_d[free_idx].vj      = opj.val;
                entries_d[free_idx].vk      = opk.val;
                entries_d[free_idx].qj      = issue_qj;
                entries_d[free_idx].qk      = issue_qk;
                entries_d[free_idx].qj_busy = opj.busy;
                entries_d[free_idx].qk_busy = opk.busy;
                entries_d[free_idx].robid   = issue_robid;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                entries_q[i] <= '0;
            end
            rs1_q   <= '0;
            rs2_q   <= '0;
            op_q    <= OP_NONE;
            robid_q <= '0;
        end else begin
            for (int i = 0; i < RS_SIZE; i++) begin
                entries_q[i] <= entries_d[i];
            end
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            op_q    <= op_d;
            robid_q <= robid_d;
        end
    end

    assign rs1   = rs1_q;
    assign rs2   = rs2_q;
    assign op    = op_q;
    assign robid = robid_q;

endmodule

// File: tb/tb_alu_rs.sv
// Directed self-checking bench for alu_rs; inputs change 1ns after each posedge
// and outputs are sampled at the same point, reflecting the edge just taken.
module tb_alu_rs;
    import alu_rs_pkg::*;

    logic             clk_in;
    logic             rst_in;
    logic             rdy_in;
    logic             rob_clear;
    logic             issue_valid;
    logic [OP_W-1:0]  issue_op;
    logic [31:0]      issue_vj;
    logic [31:0]      issue_vk;
    logic             issue_qj_busy;
    logic             issue_qk_busy;
    logic [ROB_W-1:0] issue_qj;
    logic [ROB_W-1:0] issue_qk;
    logic [ROB_W-1:0] issue_robid;
    logic             rs_full;
    logic             alu_valid;
    logic [ROB_W-1:0] alu_robid;
    logic [31:0]      alu_result;
    logic             lsb_valid;
    logic [ROB_W-1:0] lsb_robid;
    logic [31:0]      lsb_result;
    logic [31:0]      rs1;
    logic [31:0]      rs2;
    logic [OP_W-1:0]  op;
    logic [ROB_W-1:0] robid;

    int tests_run;
    int tests_failed;

    alu_rs dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .rdy_in        (rdy_in),
        .rob_clear     (rob_clear),
        .issue_valid   (issue_valid),
        .issue_op      (issue_op),
        .issue_vj      (issue_vj),
        .issue_vk      (issue_vk),
        .issue_qj_busy (issue_qj_busy),
        .issue_qk_busy (issue_qk_busy),
        .issue_qj      (issue_qj),
        .issue_qk      (issue_qk),
        .issue_robid   (issue_robid),
        .rs_full       (rs_full),
        .alu_valid     (alu_valid),
        .alu_robid     (alu_robid),
        .alu_result    (alu_result),
        .lsb_valid     (lsb_valid),
        .lsb_robid     (lsb_robid),
        .lsb_result    (lsb_result),
        .rs1           (rs1),
        .rs2           (rs2),
        .op            (op),
        .robid         (robid)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic clear_inputs();
        rob_clear     = 1'b0;
        issue_valid   = 1'b0;
        issue_op      = OP_NONE;
        issue_vj      = '0;
        issue_vk      = '0;
        issue_qj_busy = 1'b0;
        issue_qk_busy = 1'b0;
        issue_qj      = '0;
        issue_qk      = '0;
        issue_robid   = '0;
        alu_valid     = 1'b0;
        alu_robid     = '0;
        alu_result    = '0;
        lsb_valid     = 1'b0;
        lsb_robid     = '0;
        lsb_result    = '0;
    endtask

    task automatic drive_issue(input logic [OP_W-1:0] o, input logic [31:0] vj, input logic [31:0] vk,
                               input logic qjb, input logic [ROB_W-1:0] qj,
                               input logic qkb, input logic [ROB_W-1:0] qk,
                               input logic [ROB_W-1:0] rid);
        issue_valid   = 1'b1;
        issue_op      = o;
        issue_vj      = vj;
        issue_vk      = vk;
        issue_qj_busy = qjb;
        issue_qj      = qj;
        issue_qk_busy = qkb;
        issue_qk      = qk;
        issue_robid   = rid;
    endtask

    task automatic test_reset();
        rst_in = 1'b1;
        rdy_in = 1'b1;
        clear_inputs();
        tick();
        tick();
        rst_in = 1'b0;
        tests_run++;
        if (rs1 !== 32'd0 || rs2 !== 32'd0 || robid !== 4'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_outputs: rs1=%0d rs2=%0d robid=%0d expected all 0", rs1, rs2, robid);
        end
        for (int c = 0; c < 10; c++) begin
            tick();
            tests_run++;
            if (op !== OP_NONE || rs_full !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL reset_idle cycle %0d: op=%0d rs_full=%0b expected op=0 rs_full=0", c, op, rs_full);
            end
        end
    endtask

    task automatic test_add();
        drive_issue(OP_ADD, 32'd5, 32'd7, 1'b0, 4'd0, 1'b0, 4'd0, 4'd3);
        tick();
        clear_inputs();
        tests_run++;
        if (op !== OP_NONE) begin
            tests_failed++;
            $display("[TB] FAIL add_issue_edge: op=%0d expected 0", op);
        end
        tick();
        tests_run++;
        if (rs1 !== 32'd5 || rs2 !== 32'd7 || op !== OP_ADD || robid !== 4'd3) begin
            tests_failed++;
            $display("[TB] FAIL add_dispatch: rs1=%0d rs2=%0d op=%0d robid=%0d expected 5 7 1 3", rs1, rs2, op, robid);
        end
        tick();
        tests_run++;
        if (op !== OP_NONE) begin
            tests_failed++;
            $display("[TB] FAIL add_freed: op=%0d expected 0", op);
        end
    endtask

    task automatic test_wakeup();
        drive_issue(OP_SUB, 32'd0, 32'd1, 1'b1, 4'd2, 1'b0, 4'd0, 4'd5);
        tick();
        clear_inputs();
        alu_valid  = 1'b1;
        alu_robid  = 4'd2;
        alu_result = 32'd10;
        tick();
        clear_inputs();
        tests_run++;
        if (op !== OP_NONE) begin
            tests_failed++;
            $display("[TB] FAIL wakeup_no_bypass: op=%0d expected 0", op);
        end
        tick();
        tests_run++;
        if (rs1 !== 32'd10 || rs2 !== 32'd1 || op !== OP_SUB || robid !== 4'd5) begin
            tests_failed++;
            $display("[TB] FAIL wakeup_dispatch: rs1=%0d rs2=%0d op=%0d robid=%0d expected 10 1 2 5", rs1, rs2, op, robid);
        end
    endtask

    task automatic test_issue_snoop();
        drive_issue(OP_XOR, 32'd3, 32'd0, 1'b0, 4'd0, 1'b1, 4'd4, 4'd6);
        lsb_valid  = 1'b1;
        lsb_robid  = 4'd4;
        lsb_result = 32'hFF;
        tick();
        clear_inputs();
        tick();
        tests_run++;
        if (rs1 !== 32'd3 || rs2 !== 32'hFF || op !== OP_XOR || robid !== 4'd6) begin
            tests_failed++;
            $display("[TB] FAIL issue_snoop: rs1=%0d rs2=%0h op=%0d robid=%0d expected 3 ff 3 6", rs1, rs2, op, robid);
        end
    endtask

    task automatic test_back_to_back();
        drive_issue(OP_ADD, 32'd100, 32'd1, 1'b0, 4'd0, 1'b0, 4'd0, 4'd1);
        tick();
        drive_issue(OP_SUB, 32'd50, 32'd8, 1'b0, 4'd0, 1'b0, 4'd0, 4'd2);
        tick();
        clear_inputs();
        tests_run++;
        if (rs1 !== 32'd100 || rs2 !== 32'd1 || op !== OP_ADD || robid !== 4'd1) begin
            tests_failed++;
            $display("[TB] FAIL b2b_first: rs1=%0d rs2=%0d op=%0d robid=%0d expected 100 1 1 1", rs1, rs2, op, robid);
        end
        tick();
        tests_run++;
        if (rs1 !== 32'd50 || rs2 !== 32'd8 || op !== OP_SUB || robid !== 4'd2) begin
            tests_failed++;
            $display("[TB] FAIL b2b_second: rs1=%0d rs2=%0d op=%0d robid=%0d expected 50 8 2 2", rs1, rs2, op, robid);
        end
    endtask

    task automatic test_freeze();
        drive_issue(OP_XOR, 32'd20, 32'd21, 1'b0, 4'd0, 1'b0, 4'd0, 4'd7);
        tick();
        rdy_in = 1'b0;
        drive_issue(OP_ADD, 32'd99, 32'd99, 1'b0, 4'd0, 1'b0, 4'd0, 4'd9);
        tick();
        clear_inputs();
        tests_run++;
        if (op !== OP_NONE || rs1 !== 32'd50 || rs2 !== 32'd8 || robid !== 4'd2) begin
            tests_failed++;
            $display("[TB] FAIL freeze_hold: op=%0d rs1=%0d rs2=%0d robid=%0d expected 0 50 8 2", op, rs1, rs2, robid);
        end
        rdy_in = 1'b1;
        tick();
        tests_run++;
        if (rs1 !== 32'd20 || rs2 !== 32'd21 || op !== OP_XOR || robid !== 4'd7) begin
            tests_failed++;
            $display("[TB] FAIL freeze_resume: rs1=%0d rs2=%0d op=%0d robid=%0d expected 20 21 3 7", rs1, rs2, op, robid);
        end
        tick();
        tests_run++;
        if (op !== OP_NONE) begin
            tests_failed++;
            $display("[TB] FAIL freeze_issue_ignored: op=%0d expected 0", op);
        end
    endtask

    task automatic test_full();
        for (int i = 0; i < 8; i++) begin
            drive_issue(OP_ADD, 32'd0, 32'(100 + i), 1'b1, ROB_W'(i), 1'b0, 4'd0, ROB_W'(i));
            tick();
            if (i == 6) begin
                tests_run++;
                if (rs_full !== 1'b0) begin
                    tests_failed++;
                    $display("[TB] FAIL full_seven: rs_full=%0b expected 0", rs_full);
                end
            end
        end
        clear_inputs();
        tests_run++;
        if (rs_full !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL full_eight: rs_full=%0b expected 1", rs_full);
        end
        $display("[TB] note: issuing into a full station on purpose; it must be dropped");
        drive_issue(OP_XOR, 32'd9, 32'd9, 1'b0, 4'd0, 1'b0, 4'd0, 4'd9);
        tick();
        clear_inputs();
        tick();
        tests_run++;
        if (op !== OP_NONE || rs_full !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL full_drop: op=%0d rs_full=%0b expected 0 1", op, rs_full);
        end
        alu_valid  = 1'b1;
        alu_robid  = 4'd0;
        alu_result = 32'd42;
        tick();
        clear_inputs();
        tests_run++;
        if (op !== OP_NONE || rs_full !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL full_wake_edge: op=%0d rs_full=%0b expected 0 1", op, rs_full);
        end
        tick();
        tests_run++;
        if (rs1 !== 32'd42 || rs2 !== 32'd100 || op !== OP_ADD || robid !== 4'd0 || rs_full !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL full_wake_dispatch: rs1=%0d rs2=%0d op=%0d robid=%0d rs_full=%0b expected 42 100 1 0 0",
                     rs1, rs2, op, robid, rs_full);
        end
        rob_clear = 1'b1;
        tick();
        clear_inputs();
    endtask

    task automatic test_flush();
        for (int i = 0; i < 5; i++) begin
            drive_issue(OP_SUB, 32'd0, 32'd1, 1'b1, ROB_W'(8 + i), 1'b0, 4'd0, ROB_W'(8 + i));
            tick();
        end
        clear_inputs();
        rob_clear = 1'b1;
        alu_valid = 1'b1;
        alu_robid = 4'd8;
        tick();
        clear_inputs();
        tests_run++;
        if (op !== OP_NONE || rs1 !== 32'd0 || robid !== 4'd0 || rs_full !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL flush_outputs: op=%0d rs1=%0d robid=%0d rs_full=%0b expected 0 0 0 0", op, rs1, robid, rs_full);
        end
        alu_valid  = 1'b1;
        alu_robid  = 4'd8;
        alu_result = 32'd77;
        tick();
        clear_inputs();
        tick();
        tests_run++;
        if (op !== OP_NONE) begin
            tests_failed++;
            $display("[TB] FAIL flush_entries_gone: op=%0d expected 0", op);
        end
        drive_issue(OP_ADD, 32'd1, 32'd2, 1'b0, 4'd0, 1'b0, 4'd0, 4'd13);
        tick();
        clear_inputs();
        tick();
        tests_run++;
        if (rs1 !== 32'd1 || rs2 !== 32'd2 || op !== OP_ADD || robid !== 4'd13) begin
            tests_failed++;
            $display("[TB] FAIL flush_reissue: rs1=%0d rs2=%0d op=%0d robid=%0d expected 1 2 1 13", rs1, rs2, op, robid);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_add();
        test_wakeup();
        test_issue_snoop();
        test_back_to_back();
        test_freeze();
        test_full();
        test_flush();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/alu_rs.md
Name: alu_rs

Overview:
- ALU reservation station; sits between issue/decode and the ALU.
- Buffers issued ALU-class instructions (op, two operands or their RoB tags, destination robid).
- Snoops the CDB (ALU and load/store broadcasts) to wake up pending operands.
- Each cycle, dispatches at most one ready entry to the ALU through registered rs1/rs2/op/robid outputs.

Parameters:
- RS_SIZE, 8, number of entries; power of two, ≥2.
- ROB_W, `RoB_addr, RoB tag width.
- OP_W, 6, opcode width; op = 0 means "no instruction".

Ports:
- clk_in  in  1  clock.
- rst_in  in  1  synchronous active-high reset.
- rdy_in  in  1  global ready; low = freeze state.
- rob_clear  in  1  misprediction flush.
- issue_valid  in  1  issue one instruction this cycle.
- issue_op  in  OP_W  operation code (`Add, `Beq, ...).
- issue_vj  in  32  operand 1 value; valid when issue_qj_busy = 0.
- issue_vk  in  32  operand 2 value or immediate; valid when issue_qk_busy = 0.
- issue_qj_busy  in  1  operand 1 awaits a RoB tag.
- issue_qk_busy  in  1  operand 2 awaits a RoB tag.
- issue_qj  in  ROB_W  producer tag for operand 1.
- issue_qk  in  ROB_W  producer tag for operand 2.
- issue_robid  in  ROB_W  destination RoB entry.
- rs_full  out  1  no free entry.
- alu_valid  in  1  ALU broadcast valid.
- alu_robid  in  ROB_W  ALU broadcast tag.
- alu_result  in  32  ALU broadcast value.
- lsb_valid  in  1  load/store broadcast valid.
- lsb_robid  in  ROB_W  load/store broadcast tag.
- lsb_result  in  32  load/store broadcast value.
- rs1  out  32  dispatched operand 1.
- rs2  out  32  dispatched operand 2.
- op  out  OP_W  dispatched op; 0 means idle.
- robid  out  ROB_W  dispatched tag.

Behaviour:
- Reset (rst_in = 1 at posedge):
  - all entries not busy;
  - rs1 = rs2 = 0, op = 0, robid = 0;
  - rs_full = 0.
- rob_clear = 1 at posedge: same effect as reset on all entries and outputs. This overrides a simultaneous issue, wakeup or dispatch.
- rdy_in = 0 at posedge:
  - entries, issue and wakeup are all frozen;
  - op <= 0 so the ALU sees no duplicate;
  - rs1, rs2 and robid hold their values.
- Entry state: busy, op, vj, vk, qj, qk, qj_busy, qk_busy, robid.
- Entry is ready when busy & !qj_busy & !qk_busy.
- rs_full is combinational: asserted when the busy count equals RS_SIZE, computed from registered state only.
- Issue (issue_valid & !rs_full):
  - write the lowest-index free entry at the posedge.
  - issue_valid while rs_full: the instruction is dropped. Upstream must not do this; the bench flags it.
- Issue-cycle snoop:
  - if issue_qj_busy and a CDB source (alu or lsb) is valid with a matching tag in the same cycle, store the value with qj_busy = 0.
  - same rule for qk.
  - ALU has priority over lsb when both match (both matching is a protocol error; the value is identical).
- Wakeup: every busy entry with qj_busy and qj == a valid CDB tag captures that value and clears qj_busy at the posedge. Same for qk. Both operands may wake in the same cycle.
- Dispatch, at each posedge:
  - select the lowest-index entry that is ready in the current registered state;
  - drive rs1 <= vj, rs2 <= vk, op <= entry op, robid <= entry robid;
  - clear its busy bit;
  - if no entry is ready, op <= 0.
- Latency:
  - issue with ready operands at edge t → op output at edge t+1 → ALU result at edge t+2.
  - wakeup at edge t → earliest dispatch at edge t+1.
  - no same-edge CDB-to-dispatch bypass.
- An entry freed by dispatch at edge t is reusable by issue at edge t+1 (rs_full drops after the edge).
- Issue and dispatch in the same cycle target different entries: the issue target is free, the dispatched entry is busy.
- Stores no result; the ALU owns the computation. The RS passes op codes unchanged.

Decomposition:
- Op codes and `RoB_addr stay in const.v (existing shared package).
- Add an `RS_size macro there.
- One natural sub-module: alu_rs_pick, a combinational priority encoder. Outputs: lowest free index, lowest ready index, and valid flags for each.

Test Plan:
- Reset then idle for 10 cycles → op = 0 and rs_full = 0 throughout.
- Issue `Add, vj = 5, vk = 7, both operands ready, robid = 3 → at edge t+1: rs1 = 5, rs2 = 7, op = `Add, robid = 3; entry freed.
- Issue `Sub, qj = 2 busy, vk = 1. Next cycle: alu_valid, alu_robid = 2, alu_result = 10 → dispatch the following edge with rs1 = 10, rs2 = 1.
- Issue `Xor with qk = 4 busy in the same cycle as lsb_valid, lsb_robid = 4, lsb_result = 0xFF → captured at issue; dispatches next edge with rs2 = 0xFF.
- Fill all 8 entries with unresolved tags → rs_full = 1 and a 9th issue is dropped. Wake tag 0: entry 0 dispatches and rs_full deasserts.
- Fill 5 entries, assert rob_clear → all entries empty and op = 0. Next-cycle issue lands in entry 0 and dispatches normally.
